// File: rtl/riscv_types.sv
// Shared types for the fetch-side branch predictor: counter states and BTB entry layout.
package riscv_types;

    localparam int BP_XLEN = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    // Tag and target are sized for the widest supported PC; narrower tags are zero-extended.
    typedef struct packed {
        logic               valid;
        logic [BP_XLEN-1:0] tag;
        logic [BP_XLEN-1:0] target;
        bht_state_t         ctr;
        logic               jmp;
    } btb_entry_t;

    localparam bht_state_t BP_RESET_CTR = WNT;

endpackage

// File: rtl/bp_sat_counter.sv
// Two-bit saturating counter next-state logic; holds at SNT and ST instead of wrapping.
module bp_sat_counter
    import riscv_types::*;
(
    input  bht_state_t i_ctr,
    input  logic       i_inc,
    input  logic       i_dec,
    output bht_state_t o_ctr
);

    // Next counter state; conflicting or absent requests leave the state unchanged.
    always_comb begin
        o_ctr = i_ctr;
        if (i_inc && !i_dec) begin
            case (i_ctr)
                SNT:     o_ctr = WNT;
                WNT:     o_ctr = WT;
                WT:      o_ctr = ST;
                ST:      o_ctr = ST;
                default: o_ctr = i_ctr;
            endcase
        end else if (i_dec && !i_inc) begin
            case (i_ctr)
                SNT:     o_ctr = SNT;
                WNT:     o_ctr = SNT;
                WT:      o_ctr = WNT;
                ST:      o_ctr = WT;
                default: o_ctr = i_ctr;
            endcase
        end else begin
            o_ctr = i_ctr;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor with 2-bit counters, trained from execute-stage resolution.
// Optional performance counters are built when BRANCH_PREDICTOR_PERF_EN is defined.
module branch_predictor
    import riscv_types::*;
#(
    parameter int ENTRIES = 64,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
`ifdef BRANCH_PREDICTOR_PERF_EN
    output logic [31:0]     perf_resolved,
    output logic [31:0]     perf_mispredict,
`endif
    output logic [XLEN-1:0] redirect_pc
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    btb_entry_t r_btb [ENTRIES];

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    btb_entry_t       w_if_ent;
    btb_entry_t       w_ex_ent;
    logic             w_if_hit;
    logic             w_ex_hit;
    bht_state_t       w_ctr_next;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[XLEN-1:IDX_W+2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[XLEN-1:IDX_W+2];
    assign w_if_ent = r_btb[w_if_idx];
    assign w_ex_ent = r_btb[w_ex_idx];
    assign w_if_hit = w_if_ent.valid && (w_if_ent.tag == BP_XLEN'(w_if_tag));
    assign w_ex_hit = w_ex_ent.valid && (w_ex_ent.tag == BP_XLEN'(w_ex_tag));

    bp_sat_counter u_ctr (
        .i_ctr (w_ex_ent.ctr),
        .i_inc (ex_taken),
        .i_dec (!ex_taken),
        .o_ctr (w_ctr_next)
    );

    // Fetch lookup; reads pre-update array contents, so no write bypass exists.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = {XLEN{1'b0}};
        if (reset) begin
            pred_taken  = 1'b0;
            pred_target = {XLEN{1'b0}};
        end else if (w_if_hit && (w_if_ent.jmp || (w_if_ent.ctr inside {WT, ST}))) begin
            pred_taken  = 1'b1;
            pred_target = w_if_ent.target[XLEN-1:0];
        end else begin
            pred_taken  = 1'b0;
            pred_target = {XLEN{1'b0}};
        end
    end

    // Mispredict detection; a non-control instruction predicted taken is an alias hit.
    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = {XLEN{1'b0}};
        if (reset || !ex_valid) begin
            mispredict = 1'b0;
        end else if (ex_is_branch || ex_is_jump) begin
            mispredict = (ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target != ex_pred_target));
        end else begin
            mispredict = ex_pred_taken;
        end
        if (mispredict) begin
            redirect_pc = ex_taken ? ex_target : (ex_pc + XLEN'(4));
        end else begin
            redirect_pc = {XLEN{1'b0}};
        end
    end

    // BTB training; reset clears every valid bit at once and drops any same-cycle update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i].valid <= 1'b0;
                r_btb[i].ctr   <= BP_RESET_CTR;
            end
        end else if (ex_valid) begin
            if (ex_is_jump) begin
                r_btb[w_ex_idx] <= '{valid: 1'b1, tag: BP_XLEN'(w_ex_tag),
                                     target: BP_XLEN'(ex_target), ctr: ST, jmp: 1'b1};
            end else if (ex_is_branch) begin
                if (w_ex_hit) begin
                    r_btb[w_ex_idx].ctr <= w_ctr_next;
                    if (ex_taken) begin
                        r_btb[w_ex_idx].target <= BP_XLEN'(ex_target);
                    end
                end else if (ex_taken) begin
                    r_btb[w_ex_idx] <= '{valid: 1'b1, tag: BP_XLEN'(w_ex_tag),
                                         target: BP_XLEN'(ex_target), ctr: WT, jmp: 1'b0};
                end
            end else if (w_ex_hit) begin
                r_btb[w_ex_idx].valid <= 1'b0;
            end
        end
    end

`ifdef BRANCH_PREDICTOR_PERF_EN
    logic [31:0] r_perf_resolved;
    logic [31:0] r_perf_mispredict;

    // Event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_resolved   <= 32'd0;
            r_perf_mispredict <= 32'd0;
        end else begin
            if (ex_valid && (ex_is_branch || ex_is_jump)) begin
                r_perf_resolved <= r_perf_resolved + 32'd1;
            end
            if (mispredict) begin
                r_perf_mispredict <= r_perf_mispredict + 32'd1;
            end
        end
    end

    assign perf_resolved   = r_perf_resolved;
    assign perf_mispredict = r_perf_mispredict;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default 64 entries, 32-bit PC).
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BRANCH_PREDICTOR_PERF_EN
    logic [31:0] perf_resolved;
    logic [31:0] perf_mispredict;
`endif

    int n_vec;
    int n_mis;

    branch_predictor #(.ENTRIES(64), .XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
`ifdef BRANCH_PREDICTOR_PERF_EN
        .perf_resolved  (perf_resolved),
        .perf_mispredict(perf_mispredict),
`endif
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        ex_valid       = 1'b0;
        ex_pc          = 32'h0;
        ex_is_branch   = 1'b0;
        ex_is_jump     = 1'b0;
        ex_taken       = 1'b0;
        ex_target      = 32'h0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 32'h0;
    endtask

    task automatic ex_drive(input logic br, input logic jmp, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_is_branch   = br;
        ex_is_jump     = jmp;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    initial begin
        n_vec = 0;
        n_mis = 0;

        // Reset held with a would-be mispredict on the execute inputs
        reset = 1'b1;
        if_pc = 32'h100;
        ex_drive(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        #2;
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'h0);
        tick();
        tick();

        reset = 1'b0;
        ex_idle();
        if_pc = 32'h100;
        #1;
        chk("cold_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("cold_pred_target", pred_target, 32'h0);

        // First taken branch allocates at WT
        ex_drive(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
        chk("alloc_mispredict", {31'd0, mispredict}, 32'd1);
        chk("alloc_redirect", redirect_pc, 32'h80);
        chk("alloc_no_bypass", {31'd0, pred_taken}, 32'd0);
        tick();
        ex_idle();
        #1;
        chk("wt_pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("wt_pred_target", pred_target, 32'h80);

        // Not-taken twice: WT -> WNT -> SNT
        ex_drive(1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        chk("nt1_mispredict", {31'd0, mispredict}, 32'd1);
        chk("nt1_redirect", redirect_pc, 32'h104);
        tick();
        ex_idle();
        #1;
        chk("wnt_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("wnt_pred_target", pred_target, 32'h0);
        ex_drive(1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b0, 32'h0);
        #1;
        chk("nt2_mispredict", {31'd0, mispredict}, 32'd0);
        chk("nt2_redirect", redirect_pc, 32'h0);
        tick();

        // SNT + taken -> WNT (saturated low, still predicts not-taken)
        ex_drive(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        ex_idle();
        #1;
        chk("snt_sat", {31'd0, pred_taken}, 32'd0);

        // Three more taken: WT, ST, ST; one not-taken leaves WT
        ex_drive(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        ex_drive(1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        tick();
        ex_idle();
        #1;
        chk("st_sat", {31'd0, pred_taken}, 32'd1);
        ex_drive(1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        tick();
        ex_idle();
        #1;
        chk("st_dec_wnt", {31'd0, pred_taken}, 32'd0);
        ex_drive(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        ex_idle();
        #1;
        chk("back_to_wt", {31'd0, pred_taken}, 32'd1);

        // Alias: non-branch at 0x200 shares index 0 with 0x100
        ex_drive(1'b0, 1'b0, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("alias_no_mp", {31'd0, mispredict}, 32'd0);
        tick();
        ex_idle();
        if_pc = 32'h200;
        #1;
        chk("alias_miss", {31'd0, pred_taken}, 32'd0);
        if_pc = 32'h100;
        #1;
        chk("alias_keep", {31'd0, pred_taken}, 32'd1);
        ex_drive(1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        #1;
        chk("alias_mispredict", {31'd0, mispredict}, 32'd1);
        chk("alias_redirect", redirect_pc, 32'h104);
        tick();
        ex_idle();
        #1;
        chk("alias_inval", {31'd0, pred_taken}, 32'd0);

        // JAL at 0x200: allocate, then retarget
        if_pc = 32'h200;
        ex_drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h0);
        #1;
        chk("jal1_mispredict", {31'd0, mispredict}, 32'd1);
        chk("jal1_redirect", redirect_pc, 32'h400);
        tick();
        ex_idle();
        #1;
        chk("jal1_pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("jal1_pred_target", pred_target, 32'h400);
        ex_drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h500, 1'b1, 32'h400);
        #1;
        chk("jal2_mispredict", {31'd0, mispredict}, 32'd1);
        chk("jal2_redirect", redirect_pc, 32'h500);
        tick();
        ex_idle();
        #1;
        chk("jal2_pred_target", pred_target, 32'h500);
        ex_drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h500, 1'b1, 32'h500);
        #1;
        chk("jal3_no_mp", {31'd0, mispredict}, 32'd0);
        tick();
        // Two not-taken branch hits drop ctr to WNT; jmp still forces taken
        ex_drive(1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h500);
        tick();
        tick();
        ex_idle();
        #1;
        chk("jmp_override", {31'd0, pred_taken}, 32'd1);
        chk("jmp_override_tgt", pred_target, 32'h500);

        // Reset mid-stream drops the pending allocation at 0x18 and clears 0x200
        reset = 1'b1;
        ex_drive(1'b1, 1'b0, 32'h18, 1'b1, 32'h60, 1'b0, 32'h0);
        #1;
        chk("midrst_pred", {31'd0, pred_taken}, 32'd0);
        chk("midrst_target", pred_target, 32'h0);
        chk("midrst_mispredict", {31'd0, mispredict}, 32'd0);
        tick();
        reset = 1'b0;
        ex_idle();
        if_pc = 32'h18;
        #1;
        chk("rst_discard", {31'd0, pred_taken}, 32'd0);
        if_pc = 32'h200;
        #1;
        chk("rst_clear", {31'd0, pred_taken}, 32'd0);

        // X flags with ex_valid low are ignored
        if_pc         = 32'h14;
        ex_is_branch  = 1'bx;
        ex_is_jump    = 1'bx;
        ex_taken      = 1'bx;
        ex_pred_taken = 1'bx;
        #1;
        chk("xflags_mp", {31'd0, mispredict}, 32'd0);
        chk("xflags_redirect", redirect_pc, 32'h0);
        tick();

        // Same-cycle lookup/update at index 5
        ex_drive(1'b1, 1'b0, 32'h14, 1'b1, 32'h40, 1'b0, 32'h0);
        #1;
        chk("same_old", {31'd0, pred_taken}, 32'd0);
        chk("same_mp", {31'd0, mispredict}, 32'd1);
        tick();
        ex_idle();
        #1;
        chk("same_new", {31'd0, pred_taken}, 32'd1);
        chk("same_new_tgt", pred_target, 32'h40);

        // Fall-through redirect wraps at the top of the address space
        ex_drive(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h80);
        #1;
        chk("wrap_mp", {31'd0, mispredict}, 32'd1);
        chk("wrap_redirect", redirect_pc, 32'h0);
        tick();
        ex_drive(1'b1, 1'b0, 32'h14, 1'b1, 32'h40, 1'b1, 32'h40);
        #1;
        chk("correct_no_mp", {31'd0, mispredict}, 32'd0);
        tick();
        ex_idle();
        #1;
`ifdef BRANCH_PREDICTOR_PERF_EN
        chk("perf_resolved", perf_resolved, 32'd3);
        chk("perf_mispredict", perf_mispredict, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
